// File: rtl/gray_sweep_controller.sv
// Gray-code sweep sequencer: walks a CUT forward and back through all 2^M codes,
// counting synchronized output edges per settle window and reporting hazardous steps.
module gray_sweep_controller #(
  parameter int M      = 3,
  parameter int SETTLE = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         cutOutput,
  output logic [M-1:0] cutInputs,
  output logic         busy,
  output logic         done,
  output logic         isThereHazard,
  output logic [M:0]   hazardStep,
  output logic [M:0]   hazardCount
);
  localparam int N  = 1 << M;
  localparam int S  = 2 * N - 1;
  localparam int CW = $clog2(SETTLE);
  localparam logic [M:0]    LAST_STEP = (M+1)'(S - 1);
  localparam logic [M:0]    NCODES    = (M+1)'(N);
  localparam logic [M:0]    MAX_COUNT = (M+1)'(S);
  localparam logic [CW-1:0] CYC_LAST  = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CYC_EVAL  = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [M:0]    step;
  logic [CW-1:0] cyc;
  logic          drainCnt;
  logic          sync1, sync2, syncPrev;
  logic [1:0]    edgeCnt;
  logic          cutEdge, evalNow, clearCnt, hazardNow;
  logic [M:0]    evalStep;

  // Steps 0..N-1 walk up, N..S-1 mirror back down to code 0.
  function automatic logic [M-1:0] grayOf(input logic [M:0] s);
    logic [M:0] b;
    b = (s < NCODES) ? s : LAST_STEP - s;
    b = b ^ (b >> 1);
    return b[M-1:0];
  endfunction

  // Windows trail the vector by two cycles to absorb synchronizer latency.
  always_comb begin
    cutEdge   = sync2 ^ syncPrev;
    evalNow   = ((state == RUN) && (cyc == CYC_EVAL) && (step != '0)) ||
                ((state == DRAIN) && drainCnt);
    clearCnt  = ((state == RUN) && (cyc == CYC_EVAL)) ||
                ((state == DRAIN) && drainCnt) ||
                ((state == IDLE) && start);
    evalStep  = (state == DRAIN) ? LAST_STEP : step - (M+1)'(1);
    hazardNow = evalNow && edgeCnt[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      syncPrev <= 1'b0;
      edgeCnt  <= 2'd0;
    end else begin
      sync1    <= cutOutput;
      sync2    <= sync1;
      syncPrev <= sync2;
      if (clearCnt)
        edgeCnt <= {1'b0, cutEdge};
      else if (cutEdge && (edgeCnt != 2'd3))
        edgeCnt <= edgeCnt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      step          <= '0;
      cyc           <= '0;
      drainCnt      <= 1'b0;
      cutInputs     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      isThereHazard <= 1'b0;
      hazardStep    <= '0;
      hazardCount   <= '0;
    end else begin
      done <= 1'b0;
      if (hazardNow) begin
        if (!isThereHazard) begin
          isThereHazard <= 1'b1;
          hazardStep    <= evalStep;
        end
        if (hazardCount != MAX_COUNT)
          hazardCount <= hazardCount + (M+1)'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state         <= RUN;
            step          <= '0;
            cyc           <= '0;
            cutInputs     <= grayOf('0);
            busy          <= 1'b1;
            isThereHazard <= 1'b0;
            hazardStep    <= '0;
            hazardCount   <= '0;
          end
        end
        RUN: begin
          if (cyc == CYC_LAST) begin
            cyc <= '0;
            if (step == LAST_STEP) begin
              state    <= DRAIN;
              drainCnt <= 1'b0;
            end else begin
              step      <= step + (M+1)'(1);
              cutInputs <= grayOf(step + (M+1)'(1));
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        DRAIN: begin
          drainCnt <= 1'b1;
          if (drainCnt) begin
            state <= IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gray_sweep_controller.sv
// Bench for gray_sweep_controller: a CUT model with injectable glitches and a
// step-level hazard model derived from the sweep list and glitch mask.
module tb_gray_sweep_controller;
  localparam int M = 3, SETTLE = 8, S = 15, RUNLEN = 122, CAP = 128;

  logic       clk = 0, rst_n = 0, start = 0;
  logic       cutOutput;
  logic [2:0] cutInputs;
  logic       busy, done, isThereHazard;
  logic [3:0] hazardStep, hazardCount;

  gray_sweep_controller #(.M(M), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cutOutput(cutOutput),
    .cutInputs(cutInputs), .busy(busy), .done(done),
    .isThereHazard(isThereHazard), .hazardStep(hazardStep), .hazardCount(hazardCount)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CUT model: buffer of bit0, optional 3-cycle glitch per masked step, optional free toggle
  int          e0 = 0;
  bit          running = 0, togEn = 0;
  logic [14:0] gmask = '0;
  logic        tog = 0, glitchOn = 0;
  assign cutOutput = cutInputs[0] ^ glitchOn ^ tog;

  always @(negedge clk) begin : cutModel
    int rel;
    logic g;
    rel = cyc - e0;
    g = 1'b0;
    if (running && rel >= 0 && rel < S * SETTLE)
      g = gmask[rel / SETTLE] && ((rel % SETTLE) >= 3) && ((rel % SETTLE) <= 5);
    glitchOn <= g;
    if (togEn) tog <= ~tog;
  end

  int expVec [0:14] = '{0, 1, 3, 2, 6, 7, 5, 4, 5, 7, 6, 2, 3, 1, 0};

  logic [2:0] vecs  [CAP];
  logic       busys [CAP];
  logic       dones [CAP];
  logic       f0, fF;
  logic [3:0] s0, c0, sF, cF;

  function automatic int firstSet(input logic [14:0] m);
    for (int i = 0; i < S; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int doneCount();
    int n = 0;
    for (int r = 0; r < CAP; r++) if (dones[r] === 1'b1) n++;
    return n;
  endfunction

  // Launches one run and records outputs at each negedge; rel 0 is the cycle after E0.
  task automatic doRun(input logic [14:0] mask, input bit poke);
    @(negedge clk);
    gmask = mask; e0 = cyc + 1; start = 1; running = 1;
    for (int r = 0; r < CAP; r++) begin
      @(negedge clk);
      vecs[r] = cutInputs; busys[r] = busy; dones[r] = done;
      if (r == 0) begin f0 = isThereHazard; s0 = hazardStep; c0 = hazardCount; end
      start = poke && (r == 9 || r == 59);
    end
    running = 0;
    fF = isThereHazard; sF = hazardStep; cF = hazardCount;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({cutInputs, busy, done, isThereHazard, hazardStep, hazardCount} !== 14'd0) begin
      errors++; $display("FAIL reset_outputs got=%0h exp=0",
        {cutInputs, busy, done, isThereHazard, hazardStep, hazardCount});
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_sweep();
    doRun('0, 0);
    for (int r = 0; r < CAP; r++) begin
      int st;
      st = (r / SETTLE > S - 1) ? S - 1 : r / SETTLE;
      if (r < RUNLEN) begin
        checks++;
        if (vecs[r] !== 3'(expVec[st])) begin
          errors++; $display("FAIL clean_vector r=%0d got=%0d exp=%0d", r, vecs[r], expVec[st]);
        end
      end
      checks++;
      if (busys[r] !== (r < RUNLEN)) begin
        errors++; $display("FAIL clean_busy r=%0d got=%0b exp=%0b", r, busys[r], r < RUNLEN);
      end
      checks++;
      if (dones[r] !== (r == RUNLEN)) begin
        errors++; $display("FAIL clean_done r=%0d got=%0b exp=%0b", r, dones[r], r == RUNLEN);
      end
    end
    checks++;
    if ({fF, cF} !== 5'd0) begin
      errors++; $display("FAIL clean_flags got=%0b/%0d exp=0/0", fF, cF);
    end
  endtask

  task automatic test_single_glitch();
    doRun(15'(1 << 4), 0);
    checks++;
    if ({fF, sF, cF} !== {1'b1, 4'd4, 4'd1}) begin
      errors++; $display("FAIL single_glitch got=%0b/%0d/%0d exp=1/4/1", fF, sF, cF);
    end
  endtask

  task automatic test_multi_glitch();
    doRun(15'h2204, 0);
    checks++;
    if ({fF, sF, cF} !== {1'b1, 4'd2, 4'd3}) begin
      errors++; $display("FAIL multi_glitch got=%0b/%0d/%0d exp=1/2/3", fF, sF, cF);
    end
    doRun('0, 0);
    checks++;
    if ({f0, s0, c0} !== 9'd0) begin
      errors++; $display("FAIL flags_cleared_at_start got=%0b/%0d/%0d exp=0/0/0", f0, s0, c0);
    end
    checks++;
    if ({fF, sF, cF} !== 9'd0) begin
      errors++; $display("FAIL clean_rerun_flags got=%0b/%0d/%0d exp=0/0/0", fF, sF, cF);
    end
  endtask

  task automatic test_start_ignored();
    doRun('0, 1);
    checks++;
    if (doneCount() != 1 || dones[RUNLEN] !== 1'b1) begin
      errors++; $display("FAIL start_while_busy dones=%0d done@122=%0b exp=1/1", doneCount(), dones[RUNLEN]);
    end
  endtask

  task automatic test_reset_midrun();
    int seen;
    @(negedge clk);
    gmask = 15'(1 << 2); e0 = cyc + 1; start = 1; running = 1;
    @(negedge clk);
    start = 0;
    repeat (49) @(negedge clk);
    checks++;
    if (isThereHazard !== 1'b1) begin
      errors++; $display("FAIL pre_reset_hazard got=%0b exp=1", isThereHazard);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({cutInputs, busy, done, isThereHazard, hazardStep, hazardCount} !== 14'd0) begin
      errors++; $display("FAIL async_reset_outputs got=%0h exp=0",
        {cutInputs, busy, done, isThereHazard, hazardStep, hazardCount});
    end
    repeat (2) @(negedge clk);
    rst_n = 1; running = 0;
    seen = 0;
    for (int r = 0; r < 130; r++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL post_reset_quiet got=%0d exp=0", seen);
    end
    doRun('0, 0);
    for (int r = 0; r < RUNLEN; r++) begin
      checks++;
      if (vecs[r] !== 3'(expVec[r / SETTLE > S - 1 ? S - 1 : r / SETTLE])) begin
        errors++; $display("FAIL rerun_vector r=%0d got=%0d", r, vecs[r]);
      end
    end
    checks++;
    if (doneCount() != 1 || dones[RUNLEN] !== 1'b1) begin
      errors++; $display("FAIL rerun_done got=%0d exp=1", doneCount());
    end
  endtask

  task automatic test_toggle_saturate();
    togEn = 1;
    doRun('0, 0);
    togEn = 0;
    checks++;
    if ({fF, sF, cF} !== {1'b1, 4'd0, 4'd15}) begin
      errors++; $display("FAIL toggle_all_steps got=%0b/%0d/%0d exp=1/0/15", fF, sF, cF);
    end
  endtask

  task automatic test_back_to_back();
    int doneRel;
    @(negedge clk);
    gmask = '0; e0 = cyc + 1; start = 1; running = 1;
    doneRel = -1;
    for (int r = 0; r < 260; r++) begin
      @(negedge clk);
      if (r == RUNLEN) begin
        checks++;
        if ({done, busy} !== 2'b10) begin
          errors++; $display("FAIL b2b_first_done got=%0b%0b exp=10", done, busy);
        end
      end
      if (r == RUNLEN + 1) begin
        checks++;
        if ({busy, done, cutInputs} !== 5'b10000) begin
          errors++; $display("FAIL b2b_restart got=%0b%0b%0d exp=1/0/0", busy, done, cutInputs);
        end
        start = 0;
      end
      if (r > RUNLEN + 1 && done === 1'b1 && doneRel < 0) doneRel = r;
    end
    running = 0;
    checks++;
    if (doneRel != 2 * RUNLEN + 1) begin
      errors++; $display("FAIL b2b_second_done got=%0d exp=%0d", doneRel, 2 * RUNLEN + 1);
    end
  endtask

  task automatic test_random_glitches();
    for (int k = 0; k < 4; k++) begin
      logic [14:0] m;
      m = 15'($urandom_range(1, 32767));
      repeat ($urandom_range(1, 5)) @(negedge clk);
      doRun(m, 0);
      checks++;
      if (fF !== 1'b1 || sF !== 4'(firstSet(m)) || cF !== 4'($countones(m))) begin
        errors++; $display("FAIL random_glitch mask=%0h got=%0b/%0d/%0d exp=1/%0d/%0d",
          m, fF, sF, cF, firstSet(m), $countones(m));
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_single_glitch();
    test_multi_glitch();
    test_start_ignored();
    test_reset_midrun();
    test_toggle_saturate();
    test_back_to_back();
    test_random_glitches();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
